// File: rtl/mask_downsampler_pkg.sv
// mask_downsampler_pkg: cell-grid constants and types shared by the
// downsampler, the k-means clusterer and the overlay.
package mask_downsampler_pkg;

    localparam int IN_WIDTH_DEF  = 1280;
    localparam int IN_HEIGHT_DEF = 720;
    localparam int FACTOR_DEF    = 4;
    localparam int THRESHOLD_DEF = 8;

    localparam int OUT_WIDTH  = IN_WIDTH_DEF / FACTOR_DEF;
    localparam int OUT_HEIGHT = IN_HEIGHT_DEF / FACTOR_DEF;

    localparam int CELL_X_W = 9;
    localparam int CELL_Y_W = 8;

    typedef logic [CELL_X_W-1:0] cell_x_t;
    typedef logic [CELL_Y_W-1:0] cell_y_t;

    // x value of the end-of-row flush beat
    localparam cell_x_t FLUSH_COL = cell_x_t'(OUT_WIDTH);

    typedef enum logic {
        WAIT_SOF,
        RUN
    } ds_state_t;

    typedef struct packed {
        cell_x_t x;
        cell_y_t y;
        logic    mask;
    } cell_beat_t;

endpackage

// File: rtl/mask_downsampler_if.sv
// mask_downsampler_if: pixel stream in (hcount/vcount/mask/valid) and
// cell stream out (x/y/mask/beat/new_frame). slave = downsampler side.
interface mask_downsampler_if ();
    import mask_downsampler_pkg::*;

    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        mask_in;
    logic        valid_in;
    cell_x_t     x_out;
    cell_y_t     y_out;
    logic        mask_out;
    logic        beat_out;
    logic        new_frame_out;

    modport master (
        output hcount_in, vcount_in, mask_in, valid_in,
        input  x_out, y_out, mask_out, beat_out, new_frame_out
    );

    modport slave (
        input  hcount_in, vcount_in, mask_in, valid_in,
        output x_out, y_out, mask_out, beat_out, new_frame_out
    );

endinterface

// File: rtl/mask_column_acc.sv
// mask_column_acc: per-cell-column population accumulators.
// Ports: idx selects the column; add_en adds add_val, rd_clr clears the
// entry (rd_data is its combinational value), clr_all zeroes every entry.
module mask_column_acc
    import mask_downsampler_pkg::*;
#(
    parameter int N = OUT_WIDTH,
    parameter int W = 5
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         clr_all,
    input  logic         add_en,
    input  logic         rd_clr,
    input  cell_x_t      idx,
    input  logic [W-1:0] add_val,
    output logic [W-1:0] rd_data
);

    logic [W-1:0] acc [N];

    assign rd_data = acc[idx];

    always_ff @(posedge clk_in) begin
        if (!rst_in || clr_all) begin
            for (int i = 0; i < N; i++) begin
                acc[i] <= '0;
            end
        end else if (add_en) begin
            acc[idx] <= acc[idx] + add_val;
        end else if (rd_clr) begin
            acc[idx] <= '0;
        end
    end

endmodule

// File: rtl/mask_downsampler.sv
// mask_downsampler: reduces each FACTORxFACTOR mask block to one cell bit.
// Ports: clk_in, rst_in (sync, active-low), bus (slave modport).
module mask_downsampler
    import mask_downsampler_pkg::*;
#(
    parameter int IN_WIDTH  = IN_WIDTH_DEF,
    parameter int IN_HEIGHT = IN_HEIGHT_DEF,
    parameter int FACTOR    = FACTOR_DEF,
    parameter int THRESHOLD = THRESHOLD_DEF
) (
    input logic               clk_in,
    input logic               rst_in,
    mask_downsampler_if.slave bus
);

    localparam int LG    = $clog2(FACTOR);
    localparam int LW    = $clog2(FACTOR + 1);
    localparam int AW    = $clog2(FACTOR * FACTOR + 1);
    localparam int OUT_W = IN_WIDTH / FACTOR;
    localparam int OUT_H = IN_HEIGHT / FACTOR;

    localparam logic [10:0]   IN_W     = 11'(IN_WIDTH);
    localparam logic [9:0]    IN_H     = 10'(IN_HEIGHT);
    localparam cell_x_t       LAST_COL = cell_x_t'(OUT_W - 1);
    localparam cell_x_t       FLUSH_X  = cell_x_t'(OUT_W);
    localparam cell_y_t       LAST_ROW = cell_y_t'(OUT_H - 1);
    localparam logic [AW-1:0] THR      = AW'(THRESHOLD);

    ds_state_t     state;
    logic [LW-1:0] local_cnt;
    cell_beat_t    cell_q;
    logic          beat_q;
    logic          nf_q;
    logic          flush_pend;
    logic          flush_last;
    logic          nf_pend;

    logic [LG-1:0] hsub;
    logic [LG-1:0] vsub;
    cell_x_t       col;
    cell_y_t       row;
    logic          pix_ok;
    logic          sof;
    logic          take;
    logic          col_end;
    logic          row_end;
    logic          add_en;
    logic          rd_clr;
    logic [AW-1:0] part;
    logic [AW-1:0] acc_rd;
    logic [AW-1:0] total;

    assign hsub    = bus.hcount_in[LG-1:0];
    assign vsub    = bus.vcount_in[LG-1:0];
    assign col     = cell_x_t'(bus.hcount_in >> LG);
    assign row     = cell_y_t'(bus.vcount_in >> LG);
    assign pix_ok  = bus.valid_in
                   && (bus.hcount_in < IN_W)
                   && (bus.vcount_in < IN_H);
    assign sof     = pix_ok
                   && (bus.hcount_in == '0)
                   && (bus.vcount_in == '0);
    assign take    = pix_ok && ((state == RUN) || sof);
    assign col_end = (hsub == {LG{1'b1}});
    assign row_end = (vsub == {LG{1'b1}});
    assign add_en  = take && col_end && !row_end;
    assign rd_clr  = take && col_end && row_end;
    assign part    = AW'(local_cnt) + AW'(bus.mask_in);
    assign total   = acc_rd + part;

    mask_column_acc #(
        .N (OUT_W),
        .W (AW)
    ) u_acc (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .clr_all (sof),
        .add_en  (add_en),
        .rd_clr  (rd_clr),
        .idx     (col),
        .add_val (part),
        .rd_data (acc_rd)
    );

    // flush_pend / nf_pend are one-cycle delay stages, independent of
    // valid_in, so input gaps never postpone the flush or frame pulse.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state      <= WAIT_SOF;
            local_cnt  <= '0;
            cell_q     <= '0;
            beat_q     <= 1'b0;
            nf_q       <= 1'b0;
            flush_pend <= 1'b0;
            flush_last <= 1'b0;
            nf_pend    <= 1'b0;
        end else begin
            beat_q     <= 1'b0;
            flush_pend <= rd_clr && (col == LAST_COL);
            nf_pend    <= flush_pend && flush_last;
            nf_q       <= nf_pend;

            unique case (state)
                WAIT_SOF: if (sof) state <= RUN;
                RUN:      state <= RUN;
            endcase

            if (take) begin
                if (hsub == '0) begin
                    local_cnt <= LW'(bus.mask_in);
                end else begin
                    local_cnt <= local_cnt + LW'(bus.mask_in);
                end
            end

            if (rd_clr) begin
                cell_q.x    <= col;
                cell_q.y    <= row;
                cell_q.mask <= (total >= THR);
                beat_q      <= 1'b1;
                flush_last  <= (row == LAST_ROW);
            end else if (flush_pend) begin
                cell_q.x    <= FLUSH_X;
                cell_q.mask <= 1'b0;
                beat_q      <= 1'b1;
            end
        end
    end

    assign bus.x_out         = cell_q.x;
    assign bus.y_out         = cell_q.y;
    assign bus.mask_out      = cell_q.mask;
    assign bus.beat_out      = beat_q;
    assign bus.new_frame_out = nf_q;

endmodule
